// File: rtl/systolic_feed_pkg.sv
// ============================================================================
// systolic_feed_pkg : shared types, defaults and lane-skew helper for the
//                     systolic feed sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_feed_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int DEF_DIM    = 8;
  localparam int DEF_RD_LAT = 1;
  localparam int MAX_DIM    = 64;
  localparam int MAX_DIM_W  = 6;

  // Lane i shifts while DIM <= ... i.e. during drain steps i .. i+dim-1.
  function automatic logic [MAX_DIM-1:0] skew_en(input int unsigned cnt,
                                                  input int unsigned dim);
    logic [MAX_DIM-1:0] en;
    en = '0;
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      if (i < dim) en[i[MAX_DIM_W-1:0]] = (cnt >= i) && (cnt < i + dim);
    end
    return en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feed_seq_skew.sv
// ============================================================================
// skew_en_gen : registered per-lane FIFO shift enable (fill broadcast or
//               drain skew).
// Revision: 1.0
// ============================================================================
`default_nettype none

module skew_en_gen
  import systolic_feed_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int CW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CW-1:0]  cnt_i,
  input  logic           drain_i,
  input  logic           fill_i,
  output logic [DIM-1:0] fifo_en_o
);

  logic [DIM-1:0] fifo_en_d;
  logic [DIM-1:0] fifo_en_q;

  always_comb begin
    fifo_en_d = '0;
    if (drain_i)     fifo_en_d = DIM'(skew_en(32'(cnt_i), DIM));
    else if (fill_i) fifo_en_d = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_en_q <= '0;
    else        fifo_en_q <= fifo_en_d;
  end

  assign fifo_en_o = fifo_en_q;

endmodule

`default_nettype wire

// File: rtl/systolic_feed_seq.sv
// ============================================================================
// systolic_feed_seq : FILL/DRAIN/FLUSH sequencer for the systolic FIFO bank.
// Optional perf counters: define SYSTOLIC_FEED_SEQ_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_feed_seq
  import systolic_feed_pkg::*;
#(
  parameter int DIM    = DEF_DIM,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int CW     = $clog2(2*DIM + RD_LAT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     hold,
  output logic                     ready,
  output logic                     busy,
  output logic                     rd_en,
  output logic [$clog2(DIM)-1:0]   rd_addr,
  output logic                     fill_sel,
  output logic [DIM-1:0]           fifo_en,
  output logic                     array_en,
  output logic                     done
`ifdef SYSTOLIC_FEED_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [15:0]              perf_stalls
`endif
);

  localparam int            AW         = $clog2(DIM);
  localparam logic [CW-1:0] DIM_C      = CW'(DIM);
  localparam logic [CW-1:0] FILL_LAST  = CW'(DIM + RD_LAT - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*DIM - 2);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(DIM - 1);

  seq_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rd_en_q, rd_en_d;
  logic [AW-1:0]  rd_addr_q;
  logic           fill_sel_q;
  logic           array_en_q;
  logic           done_q;
  logic           w_stall;
  logic           w_fill_d;
  logic [DIM-1:0] w_fifo_en;

  assign w_stall = hold && ((state_q == DRAIN) || (state_q == FLUSH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        cnt_d   = '0;
      end
      FILL: if (cnt_q == FILL_LAST) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DRAIN: if (!w_stall) begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: if (!w_stall) begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en_d = (state_d == FILL) && (cnt_d < DIM_C);

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      fill_sel_q <= 1'b0;
      array_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_en_d ? cnt_d[AW-1:0] : '0;
      fill_sel_q <= w_fill_d;
      array_en_q <= (state_d == DRAIN) || (state_d == FLUSH);
      done_q     <= (state_d == DONE);
    end
  end

  // w_fill_d is the value fill_sel takes next cycle: rd_en delayed RD_LAT cycles.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_fill_d = rd_en_q;
    end else begin : g_latn
      logic [RD_LAT-2:0] pipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= rd_en_q;
          for (int i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign w_fill_d = pipe_q[RD_LAT-2];
    end
  endgenerate

  skew_en_gen #(
    .DIM (DIM),
    .CW  (CW)
  ) u_skew (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_i     (cnt_d),
    .drain_i   (state_d == DRAIN),
    .fill_i    (w_fill_d),
    .fifo_en_o (w_fifo_en)
  );

  // A stall takes effect in the cycle hold is seen, so the frozen step replays on release.
  assign fifo_en  = w_fifo_en & ~{DIM{w_stall}};
  assign array_en = array_en_q & ~w_stall;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign fill_sel = fill_sel_q;
  assign done     = done_q;
  assign ready    = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

`ifdef SYSTOLIC_FEED_SEQ_PERF_EN
  logic [31:0] cyc_q, perf_cycles_q;
  logic [15:0] stall_q, perf_stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q         <= '0;
      stall_q       <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        cyc_q   <= '0;
        stall_q <= '0;
      end else begin
        if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
        if (w_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      end
      if (state_q == DONE) begin
        perf_cycles_q <= (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        perf_stalls_q <= stall_q;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feed_seq.sv
// ============================================================================
// tb_systolic_feed_seq : scoreboard bench for systolic_feed_seq (8x1 and 4x3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_systolic_feed_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, hold_a, start_b, hold_b;
  logic ready_a, busy_a, rd_en_a, fill_sel_a, array_en_a, done_a;
  logic [2:0] rd_addr_a;
  logic [7:0] fifo_en_a;
  logic ready_b, busy_b, rd_en_b, fill_sel_b, array_en_b, done_b;
  logic [1:0] rd_addr_b;
  logic [3:0] fifo_en_b;
`ifdef SYSTOLIC_FEED_SEQ_PERF_EN
  logic [31:0] perf_cycles_a, perf_cycles_b;
  logic [15:0] perf_stalls_a, perf_stalls_b;
`endif

  systolic_feed_seq #(.DIM(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
    .ready(ready_a), .busy(busy_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .fill_sel(fill_sel_a), .fifo_en(fifo_en_a), .array_en(array_en_a), .done(done_a)
`ifdef SYSTOLIC_FEED_SEQ_PERF_EN
    , .perf_cycles(perf_cycles_a), .perf_stalls(perf_stalls_a)
`endif
  );

  systolic_feed_seq #(.DIM(4), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b),
    .ready(ready_b), .busy(busy_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .fill_sel(fill_sel_b), .fifo_en(fifo_en_b), .array_en(array_en_b), .done(done_b)
`ifdef SYSTOLIC_FEED_SEQ_PERF_EN
    , .perf_cycles(perf_cycles_b), .perf_stalls(perf_stalls_b)
`endif
  );

  // ctl = {ready, busy, rd_en, fill_sel, array_en, done}
  typedef struct {
    logic [5:0] ctl;
    logic [7:0] fe;
    logic [2:0] ra;
    int         t;
    int         scen;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  int   scen     = 0;

  function automatic exp_t idle_exp(int t);
    exp_t e;
    e.ctl = 6'b100000; e.fe = '0; e.ra = '0; e.t = t; e.scen = scen;
    return e;
  endfunction

  // Timeline relative to the cycle in which start is sampled (t=0).
  function automatic exp_t expect_at(int dim, int rl, int t, int hs, int hl);
    exp_t e;
    logic rdy, bsy, rd, fs, ae, dn;
    logic [7:0] fe;
    logic [2:0] ra;
    int k, ee;
    rdy = 1'b0; bsy = 1'b1; rd = 1'b0; fs = 1'b0; ae = 1'b0; dn = 1'b0;
    fe = '0; ra = '0;
    if (t == 0) begin
      rdy = 1'b1; bsy = 1'b0;
    end else if (t <= dim + rl) begin
      k  = t - 1;
      rd = (k < dim);
      if (k < dim) ra = k[2:0];
      fs = (k >= rl) && (k < dim + rl);
      if (fs) for (int i = 0; i < dim; i++) fe[i] = 1'b1;
    end else if (hl > 0 && t >= hs && t < hs + hl) begin
      ae = 1'b0;
    end else begin
      ee = t - (dim + rl + 1) - ((hl > 0 && t >= hs + hl) ? hl : 0);
      if (ee <= 2*dim - 2) begin
        ae = 1'b1;
        for (int i = 0; i < dim; i++) fe[i] = (ee >= i) && (ee < i + dim);
      end else if (ee <= 3*dim - 2) begin
        ae = 1'b1;
      end else if (ee == 3*dim - 1) begin
        dn = 1'b1;
      end else begin
        rdy = 1'b1; bsy = 1'b0;
      end
    end
    e.ctl = {rdy, bsy, rd, fs, ae, dn}; e.fe = fe; e.ra = ra; e.t = t; e.scen = scen;
    return e;
  endfunction

  task automatic check_one(string nm, exp_t e, logic [5:0] ctl, logic [7:0] fe, logic [2:0] ra);
    checks++;
    if (ctl !== e.ctl || fe !== e.fe || (e.ctl[3] && ra !== e.ra)) begin
      failures++;
      $display("FAIL %s scen=%0d t=%0d got ctl=%b fifo_en=%h rd_addr=%0d exp ctl=%b fifo_en=%h rd_addr=%0d",
               nm, e.scen, e.t, ctl, fe, ra, e.ctl, e.fe, e.ra);
    end
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0)
      check_one("dim8", q_a.pop_front(),
                {ready_a, busy_a, rd_en_a, fill_sel_a, array_en_a, done_a}, fifo_en_a, rd_addr_a);
    if (q_b.size() > 0)
      check_one("dim4", q_b.pop_front(),
                {ready_b, busy_b, rd_en_b, fill_sel_b, array_en_b, done_b},
                {4'b0, fifo_en_b}, {1'b0, rd_addr_b});
  end

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b1; start_a = 1'b0; hold_a = 1'b0; start_b = 1'b0; hold_b = 1'b0;
      q_a.push_back(idle_exp(i));
    end
  endtask

  task automatic run_op(bit sel, int hs, int hl, bit fill_hold, bit keep_start, int abort_t);
    int dim, rl, last;
    bit st, hd, stop;
    dim  = sel ? 4 : 8;
    rl   = sel ? 3 : 1;
    last = dim + rl + 3*dim + hl;
    stop = 1'b0;
    for (int t = 0; t <= last && !stop; t++) begin
      @(posedge clk); #1;
      st = (t == 0) || keep_start;
      hd = (hl > 0 && t >= hs && t < hs + hl) || (fill_hold && t >= 1 && t <= dim + rl);
      if (sel) begin start_b = st; hold_b = hd; end
      else     begin start_a = st; hold_a = hd; end
      if (t == abort_t) begin
        rst_n = 1'b0; start_a = 1'b0; hold_a = 1'b0; start_b = 1'b0; hold_b = 1'b0;
        if (sel) q_b.push_back(idle_exp(t)); else q_a.push_back(idle_exp(t));
        stop = 1'b1;
      end else if (sel) begin
        q_b.push_back(expect_at(dim, rl, t, hs, hl));
      end else begin
        q_a.push_back(expect_at(dim, rl, t, hs, hl));
      end
    end
    hold_a = 1'b0; hold_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; hold_a = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    repeat (2) @(posedge clk);
    scen = 0; idle_cycles(2);

    scen = 1; run_op(1'b0, 0, 0, 1'b0, 1'b0, -1);

    scen = 2; run_op(1'b0, 0, 0, 1'b0, 1'b1, -1);
    run_op(1'b0, 0, 0, 1'b0, 1'b0, -1);

    scen = 3; run_op(1'b0, 15, 3, 1'b0, 1'b0, -1);
    idle_cycles(1);
`ifdef SYSTOLIC_FEED_SEQ_PERF_EN
    checks++;
    if (perf_cycles_a !== 32'd36 || perf_stalls_a !== 16'd3) begin
      failures++;
      $display("FAIL perf got cycles=%0d stalls=%0d exp cycles=36 stalls=3", perf_cycles_a, perf_stalls_a);
    end
`endif

    scen = 4; run_op(1'b0, 0, 0, 1'b0, 1'b0, 12);
    idle_cycles(1);
    run_op(1'b0, 0, 0, 1'b0, 1'b0, -1);

    scen = 5; run_op(1'b0, 0, 0, 1'b1, 1'b0, -1);

    scen = 6; run_op(1'b1, 0, 0, 1'b0, 1'b0, -1);
    @(posedge clk); #1;
    q_b.push_back(expect_at(4, 3, 20, 0, 0));
    idle_cycles(2);

    for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
    if (q_a.size() > 0 || q_b.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got pending=%0d exp pending=0", q_a.size() + q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
